// File: rtl/mips_fetch_unit_if.sv
// Fetch-unit bus bundle: instruction-memory address/data and the decode-side handshake.
// The master is the fetch unit; the slave is the memory/decode environment.
interface mips_fetch_unit_if #(
   parameter int unsigned PC_WIDTH    = 32,
   parameter int unsigned INSTR_WIDTH = 32
);
   logic [PC_WIDTH-1:0]    imem_pc;
   logic [INSTR_WIDTH-1:0] imem_instr;
   logic                   dec_valid;
   logic                   dec_ready;
   logic [INSTR_WIDTH-1:0] dec_instr;
   logic [PC_WIDTH-1:0]    dec_pc;
   logic [PC_WIDTH-1:0]    dec_pc_plus4;

   modport master (
      output imem_pc,
      input  imem_instr,
      output dec_valid,
      input  dec_ready,
      output dec_instr,
      output dec_pc,
      output dec_pc_plus4
   );

   modport slave (
      input  imem_pc,
      output imem_instr,
      input  dec_valid,
      output dec_ready,
      input  dec_instr,
      input  dec_pc,
      input  dec_pc_plus4
   );
endinterface

// File: rtl/mips_fetch_unit.sv
// Instruction fetch stage: drives the PC to instruction memory and queues {pc, instr}
// pairs toward decode, with redirect/flush and halt control.
module mips_fetch_unit #(
   parameter int unsigned         PC_WIDTH    = 32,
   parameter int unsigned         INSTR_WIDTH = 32,
   parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
   parameter int unsigned         BUF_DEPTH   = 2
) (
   input  logic                clk,
   input  logic                rst,
   mips_fetch_unit_if.master   bus_if,
   input  logic                redirect_valid_i,
   input  logic [PC_WIDTH-1:0] redirect_target_i,
   input  logic                halt_i,
   output logic [31:0]         fetch_count_o
);

   localparam int unsigned PtrW = $clog2(BUF_DEPTH);
   localparam int unsigned CntW = PtrW + 1;
   localparam logic [CntW-1:0] DepthCnt = CntW'(BUF_DEPTH);

   typedef enum logic [1:0] {StWarmup, StFetch, StStall, StHalted} state_e;

   state_e state_q, state_d;

   logic [PC_WIDTH-1:0]    pc_q;
   logic [PtrW-1:0]        rd_ptr_q, wr_ptr_q;
   logic [CntW-1:0]        count_q;
   logic [31:0]            fetch_count_q;
   logic [PC_WIDTH-1:0]    pc_mem_q    [BUF_DEPTH];
   logic [PC_WIDTH-1:0]    pc4_mem_q   [BUF_DEPTH];
   logic [INSTR_WIDTH-1:0] instr_mem_q [BUF_DEPTH];

   logic                dec_valid;
   logic                pop;
   logic                can_push;
   logic                push;
   logic                flush;
   logic [PC_WIDTH-1:0] pc_plus4;
   logic                unused_tgt_bits;

   assign unused_tgt_bits = ^redirect_target_i[1:0];

   assign dec_valid = (count_q != '0);
   assign pop       = dec_valid && bus_if.dec_ready;
   assign can_push  = (count_q < DepthCnt) || pop;
   assign pc_plus4  = pc_q + PC_WIDTH'(4);

   assign bus_if.imem_pc      = pc_q;
   assign bus_if.dec_valid    = dec_valid;
   assign bus_if.dec_pc       = pc_mem_q[rd_ptr_q];
   assign bus_if.dec_pc_plus4 = pc4_mem_q[rd_ptr_q];
   assign bus_if.dec_instr    = instr_mem_q[rd_ptr_q];
   assign fetch_count_o       = fetch_count_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StWarmup;
      end else begin
         state_q <= state_d;
      end
   end

   // Redirect and halt outrank everything; once halt wins, the stall/pop bookkeeping is moot.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StWarmup: state_d = halt_i ? StHalted : StFetch;
         StFetch: begin
            if (redirect_valid_i || halt_i) begin
               state_d = halt_i ? StHalted : StFetch;
            end else if (!can_push) begin
               state_d = StStall;
            end
         end
         StStall: begin
            if (redirect_valid_i || halt_i) begin
               state_d = halt_i ? StHalted : StFetch;
            end else if (pop) begin
               state_d = StFetch;
            end
         end
         StHalted: state_d = halt_i ? StHalted : StFetch;
         default:  state_d = StWarmup;
      endcase
   end

   always_comb begin
      push  = 1'b0;
      flush = 1'b0;
      unique case (state_q)
         StFetch: begin
            flush = redirect_valid_i;
            push  = !redirect_valid_i && !halt_i && can_push;
         end
         StStall, StHalted: flush = redirect_valid_i;
         default: ;
      endcase
   end

   // A redirect in warmup only retargets the PC; the buffer is necessarily empty then.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pc_q          <= RESET_PC;
         rd_ptr_q      <= '0;
         wr_ptr_q      <= '0;
         count_q       <= '0;
         fetch_count_q <= '0;
         pc_mem_q      <= '{default: '0};
         pc4_mem_q     <= '{default: '0};
         instr_mem_q   <= '{default: '0};
      end else begin
         if (redirect_valid_i) begin
            pc_q <= {redirect_target_i[PC_WIDTH-1:2], 2'b00};
         end else if (push) begin
            pc_q <= pc_plus4;
         end

         if (push && (fetch_count_q != '1)) begin
            fetch_count_q <= fetch_count_q + 32'd1;
         end

         if (flush) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
         end else begin
            if (push) begin
               pc_mem_q[wr_ptr_q]    <= pc_q;
               pc4_mem_q[wr_ptr_q]   <= pc_plus4;
               instr_mem_q[wr_ptr_q] <= bus_if.imem_instr;
               wr_ptr_q              <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
               rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
               2'b10:   count_q <= count_q + CntW'(1);
               2'b01:   count_q <= count_q - CntW'(1);
               default: count_q <= count_q;
            endcase
         end
      end
   end

endmodule

// File: doc/mips_fetch_unit.md
Name: mips_fetch_unit

Overview:
- CPU-side instruction fetch stage.
- Drives the program counter to the instruction memory and takes the returned instruction word the same cycle.
- Buffers {pc, instr} pairs in a small FIFO toward decode, with a valid/ready handshake.
- Supports branch/jump redirect (with flush) and halt.

Parameters:
- PC_WIDTH, 32, program counter width in bits.
- INSTR_WIDTH, 32, instruction word width in bits.
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- BUF_DEPTH, 2, fetch buffer entries; must be a power of two, ≥ 2.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- imem_pc  output  PC_WIDTH  address to instruction memory.
- imem_instr  input  INSTR_WIDTH  instruction word; combinational function of imem_pc, valid in the same cycle.
- redirect_valid  input  1  branch/jump taken this cycle.
- redirect_target  input  PC_WIDTH  new PC; bits [1:0] ignored (forced 0).
- halt  input  1  level; stop fetching while high.
- dec_valid  output  1  buffer head valid.
- dec_ready  input  1  decode accepts head.
- dec_instr  output  INSTR_WIDTH  head instruction.
- dec_pc  output  PC_WIDTH  head instruction address.
- dec_pc_plus4  output  PC_WIDTH  dec_pc + 4, modulo 2^PC_WIDTH.
- fetch_count  output  32  number of instructions pushed since reset; saturates at 2^32-1.

Behaviour:
- Reset (async assert, sync release): pc_q = RESET_PC; buffer empty; state = WARMUP; fetch_count = 0.
  - Reset values of data outputs: dec_valid = 0; dec_instr, dec_pc, dec_pc_plus4 = 0.
  - Reset mid-operation discards all buffered entries immediately.
- imem_pc = pc_q at all times.
- States:
  - WARMUP: one cycle, no push. Next state is HALTED if halt is high, else FETCH.
  - FETCH:
    - push = can_push, where can_push = (count < BUF_DEPTH) || (dec_valid && dec_ready).
    - On push: entry = {pc_q, imem_instr}; pc_q <= pc_q + 4 (wraps to 0 from max); fetch_count++.
    - If !can_push, go to STALL and hold pc_q.
  - STALL: no push; pc_q holds. Return to FETCH the cycle after a pop frees an entry.
  - HALTED: no push; pc_q holds; buffer still drains to decode. Exit to FETCH on the first cycle halt is low.
- halt high in FETCH or STALL: go to HALTED next cycle; no push in the cycle halt is sampled high.
- Pop: occurs when dec_valid && dec_ready; head advances. Simultaneous push and pop when full is allowed, and count stays at BUF_DEPTH.
- Redirect: highest priority, in any state except WARMUP.
  - Effects: flush buffer (count = 0, dec_valid = 0 next cycle); pc_q <= {redirect_target[PC_WIDTH-1:2], 2'b00}; no push that cycle.
  - A pop in the same cycle is still honoured for the current head, then discarded by the flush.
  - Next state: FETCH, or HALTED if halt is also high.
- Redirect during WARMUP is registered: pc_q is updated, and the state still goes to FETCH/HALTED.
- Latency: instruction at PC p is visible on dec_* one cycle after the cycle imem_pc = p was pushed.
  - Steady throughput with dec_ready high: one instruction per cycle.
- Pointers: read/write pointers wrap modulo BUF_DEPTH; count width is clog2(BUF_DEPTH)+1.
- dec_* outputs come from the buffer head register. No combinational path from imem_instr to dec_instr.

Test Plan:
- Reset then dec_ready=1, imem returns instr = pc ^ 32'hA5A5_0000:
  - imem_pc is 0x0 (WARMUP), then 0x0, 0x4, 0x8.
  - dec_pc is 0x0, 0x4, 0x8 on consecutive cycles starting 2 cycles after reset release.
  - dec_instr matches; fetch_count = 3 after 3 pushes.
- Backpressure: hold dec_ready=0 for 5 cycles after warmup.
  - Exactly 2 entries buffered (pc 0x0, 0x4); imem_pc holds 0x8; state STALL.
  - On dec_ready=1, the sequence resumes 0x0, 0x4, 0x8 with no gap or duplicate.
- Redirect while full: buffer holds 0x0, 0x4; pulse redirect_valid with target 0x0000_0103.
  - Next cycle dec_valid=0 and imem_pc=0x100.
  - Next dec_pc = 0x100; the old entries are never presented after the flush.
- Halt: assert halt for 4 cycles while buffer has 1 entry and dec_ready=1.
  - The entry drains; no pushes; fetch_count is frozen.
  - Fetch resumes at the held pc on halt release.
- Wrap: redirect to 0xFFFF_FFFC.
  - dec_pc sequence is 0xFFFF_FFFC, 0x0000_0000.
  - dec_pc_plus4 for the first entry = 0x0000_0000.
- Async reset asserted mid-stream, between clock edges:
  - dec_valid drops to 0 immediately; imem_pc = RESET_PC before the next edge.
